// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS opcode/funct constants, the symbolic mnemonic codes
// accepted by the instruction encoder, and the legal mnemonic bound.
// Shared by the encoder and the control decoder's tests.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    M_ADD  = 5'd0,  M_ADDU = 5'd1,  M_SUB  = 5'd2,  M_SUBU = 5'd3,
    M_AND  = 5'd4,  M_OR   = 5'd5,  M_NOR  = 5'd6,  M_SLT  = 5'd7,
    M_SLTU = 5'd8,  M_SLL  = 5'd9,  M_SRL  = 5'd10, M_SLLV = 5'd11,
    M_SRLV = 5'd12, M_JR   = 5'd13, M_JALR = 5'd14,
    M_ADDI = 5'd15, M_SLTI = 5'd16, M_ANDI = 5'd17, M_ORI  = 5'd18,
    M_LUI  = 5'd19, M_LW   = 5'd20, M_SW   = 5'd21, M_BEQ  = 5'd22,
    M_BNE  = 5'd23,
    M_J    = 5'd24, M_JAL  = 5'd25
  } mnem_e;

  // Codes at or above this bound are illegal.
  localparam logic [4:0] MNEM_LIMIT = 5'd26;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_BAD} fmt_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

endpackage

// File: rtl/instr_enc_pack.sv
// instr_enc_pack: combinational packer, mnemonic + fields -> 32-bit MIPS word.
// Ports: mnem/rs/rt/rd/sa/imm/target in; word (encoded instruction) and
// legal (mnemonic is a defined code) out. word is 0 when legal is 0.
module instr_enc_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sa,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  fmt_e       fmt;
  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs_f, rt_f, rd_f, sa_f;

  // Classify the mnemonic and apply the per-instruction field forcing.
  always_comb begin
    fmt   = FMT_BAD;
    op    = OP_RTYPE;
    funct = '0;
    rs_f  = rs;
    rt_f  = rt;
    rd_f  = rd;
    sa_f  = '0;
    case (mnem)
      M_ADD:  begin fmt = FMT_R; funct = FN_ADD;  end
      M_ADDU: begin fmt = FMT_R; funct = FN_ADDU; end
      M_SUB:  begin fmt = FMT_R; funct = FN_SUB;  end
      M_SUBU: begin fmt = FMT_R; funct = FN_SUBU; end
      M_AND:  begin fmt = FMT_R; funct = FN_AND;  end
      M_OR:   begin fmt = FMT_R; funct = FN_OR;   end
      M_NOR:  begin fmt = FMT_R; funct = FN_NOR;  end
      M_SLT:  begin fmt = FMT_R; funct = FN_SLT;  end
      M_SLTU: begin fmt = FMT_R; funct = FN_SLTU; end
      M_SLL:  begin fmt = FMT_R; funct = FN_SLL; rs_f = '0; sa_f = sa; end
      M_SRL:  begin fmt = FMT_R; funct = FN_SRL; rs_f = '0; sa_f = sa; end
      M_SLLV: begin fmt = FMT_R; funct = FN_SLLV; end
      M_SRLV: begin fmt = FMT_R; funct = FN_SRLV; end
      M_JR:   begin fmt = FMT_R; funct = FN_JR; rt_f = '0; rd_f = '0; end
      M_JALR: begin fmt = FMT_R; funct = FN_JALR; rt_f = '0; end
      M_ADDI: begin fmt = FMT_I; op = OP_ADDI; end
      M_SLTI: begin fmt = FMT_I; op = OP_SLTI; end
      M_ANDI: begin fmt = FMT_I; op = OP_ANDI; end
      M_ORI:  begin fmt = FMT_I; op = OP_ORI;  end
      M_LUI:  begin fmt = FMT_I; op = OP_LUI; rs_f = '0; end
      M_LW:   begin fmt = FMT_I; op = OP_LW;   end
      M_SW:   begin fmt = FMT_I; op = OP_SW;   end
      M_BEQ:  begin fmt = FMT_I; op = OP_BEQ;  end
      M_BNE:  begin fmt = FMT_I; op = OP_BNE;  end
      M_J:    begin fmt = FMT_J; op = OP_J;    end
      M_JAL:  begin fmt = FMT_J; op = OP_JAL;  end
      default: fmt = FMT_BAD;
    endcase
    if (mnem >= MNEM_LIMIT) fmt = FMT_BAD;
  end

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (fmt)
      FMT_R:   word = {OP_RTYPE, rs_f, rt_f, rd_f, sa_f, funct};
      FMT_I:   word = {op, rs_f, rt_f, imm};
      FMT_J:   word = {op, target};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: sequential MIPS instruction encoder / program loader.
// Accepts symbolic beats over in_valid/in_ready, packs each into a 32-bit
// word and writes it to instruction memory at consecutive word addresses
// starting from BASE_ADDR after each start pulse.
// Ports: clk, rstn (async active-low), start, beat inputs (in_valid, in_mnem,
// in_rs/rt/rd/sa, in_imm, in_target, in_last), in_ready; memory write port
// im_we/im_addr/im_wdata; status count, busy, done, err (sticky illegal
// mnemonic), ovf (sticky address-space exhaustion). All outputs registered.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_mnem,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_sa,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  input  logic                  in_last,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ovf
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  state_e                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           enc_word;
  logic                  enc_legal;
  logic                  accept;
  logic                  at_top;

  instr_enc_pack u_pack (
    .mnem   (in_mnem),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .sa     (in_sa),
    .imm    (in_imm),
    .target (in_target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  // in_ready is a flop that is high exactly while in LOAD.
  assign accept = in_valid && in_ready;
  assign at_top = (addr == '1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      addr     <= BASE;
      in_ready <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= BASE;
      im_wdata <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      im_we <= 1'b0;
      if (start) begin
        // start wins over any beat presented in the same cycle.
        state    <= S_LOAD;
        addr     <= BASE;
        im_addr  <= BASE;
        count    <= '0;
        err      <= 1'b0;
        ovf      <= 1'b0;
        in_ready <= 1'b1;
        busy     <= 1'b1;
        done     <= 1'b0;
      end else if (accept) begin
        if (enc_legal) begin
          im_we    <= 1'b1;
          im_addr  <= addr;
          im_wdata <= enc_word;
          count    <= count + 1'b1;
          // The top word ends the session; the address never wraps.
          if (!at_top) addr <= addr + 1'b1;
          if (at_top && !in_last) ovf <= 1'b1;
        end else begin
          err <= 1'b1;
        end
        if (in_last || (enc_legal && at_top)) begin
          state    <= S_DONE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule
